// File: rtl/rtc_pkg.sv
// Shared constants for the alarm clock: set-mode encodings and field limits.
// Latency: n/a (constants and pure helper functions only).
// Backpressure: n/a.
package rtc_pkg;

   // Set-mode FSM encodings, also visible on the mode output
   localparam logic [2:0] MODE_RUN         = 3'd0;
   localparam logic [2:0] MODE_SET_SEC     = 3'd1;
   localparam logic [2:0] MODE_SET_MIN     = 3'd2;
   localparam logic [2:0] MODE_SET_HOUR    = 3'd3;
   localparam logic [2:0] MODE_SET_AL_MIN  = 3'd4;
   localparam logic [2:0] MODE_SET_AL_HOUR = 3'd5;

   localparam int SEC_MAX  = 59;
   localparam int MIN_MAX  = 59;
   localparam int HOUR_MAX = 23;

   // Successor state on a set_time event; SET_AL_HOUR wraps back to RUN
   function automatic logic [2:0] next_mode(input logic [2:0] m);
      return (m == MODE_SET_AL_HOUR) ? MODE_RUN : m + 3'd1;
   endfunction

   // Time keeps running everywhere except while the time fields are being edited
   function automatic logic time_runs(input logic [2:0] m);
      return !((m == MODE_SET_SEC) || (m == MODE_SET_MIN) || (m == MODE_SET_HOUR));
   endfunction

endpackage

// File: rtl/rtc_mod_counter.sv
// Modulo-(MAX+1) counter: i_en counts with carry-out, i_inc bumps without carry.
// Latency: value updates on the clock edge after i_en/i_inc; carry is combinational.
// Backpressure: none; every enable or inc pulse is consumed.
module rtc_mod_counter
   import rtc_pkg::*;
#(
   parameter int MAX = 59,
   parameter int W   = 6
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_en,
   input  logic         i_inc,
   output logic [W-1:0] o_val,
   output logic         o_carry
);

   logic [W-1:0] r_val;
   logic         w_wrap;

   assign w_wrap  = (r_val == W'(MAX));
   // carry only propagates for real time advance, never for a manual inc
   assign o_carry = i_en & w_wrap;
   assign o_val   = r_val;

   // wrap to zero past MAX, otherwise count up on either enable
   always_ff @(posedge clk) begin
      if (reset)
         r_val <= '0;
      else if (i_en || i_inc)
         r_val <= w_wrap ? '0 : r_val + W'(1);
   end

endmodule

// File: rtl/rtc_alarm_clock.sv
// Real-time clock with set-mode FSM, alarm compare and bounded alarm duration.
// Latency: fields, mode and alarm are registered (1 cycle); sec_tick is combinational.
// Backpressure: none; level inputs are edge-detected and each edge acts once.
module rtc_alarm_clock
   import rtc_pkg::*;
#(
   parameter int TICK_DIV  = 1,
   parameter int ALARM_LEN = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_set_time,
   input  logic       i_inc,
   input  logic       i_alarm_en,
   input  logic       i_alarm_ack,
   output logic [4:0] o_hour,
   output logic [5:0] o_minute,
   output logic [5:0] o_second,
   output logic [4:0] o_alarm_hour,
   output logic [5:0] o_alarm_minute,
   output logic       o_alarm,
   output logic [2:0] o_mode,
   output logic       o_sec_tick
);

   localparam int            PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
   localparam int            AW     = $clog2(ALARM_LEN + 1);
   localparam logic [AW-1:0] A_LOAD = AW'(ALARM_LEN);

   logic          r_set_d, r_inc_d, r_ack_d;
   logic [2:0]    r_mode;
   logic [PW-1:0] r_presc;
   logic          r_alarm;
   logic [AW-1:0] r_acnt;

   logic       w_set_ev, w_inc_ev, w_ack_ev, w_run, w_tick;
   logic       w_inc_sec, w_inc_min, w_inc_hour, w_inc_almin, w_inc_alhour;
   logic       w_sec_carry, w_min_carry;
   logic       w_unused_hour_carry, w_unused_almin_carry, w_unused_alhour_carry;
   logic [5:0] w_min_nxt;
   logic [4:0] w_hour_nxt;
   logic       w_trig;

   assign w_set_ev = i_set_time  & ~r_set_d;
   assign w_inc_ev = i_inc       & ~r_inc_d;
   assign w_ack_ev = i_alarm_ack & ~r_ack_d;

   assign w_run  = time_runs(r_mode);
   // gated by reset so the pulse is quiet while held in reset even with TICK_DIV=1
   assign w_tick = w_run & (r_presc == P_LAST) & ~reset;

   assign w_inc_sec    = w_inc_ev & (r_mode == MODE_SET_SEC);
   assign w_inc_min    = w_inc_ev & (r_mode == MODE_SET_MIN);
   assign w_inc_hour   = w_inc_ev & (r_mode == MODE_SET_HOUR);
   assign w_inc_almin  = w_inc_ev & (r_mode == MODE_SET_AL_MIN);
   assign w_inc_alhour = w_inc_ev & (r_mode == MODE_SET_AL_HOUR);

   // hour:minute as they will read after this edge, for the alarm compare
   assign w_min_nxt  = (o_minute == 6'(MIN_MAX)) ? 6'd0 : o_minute + 6'd1;
   assign w_hour_nxt = w_min_carry ? ((o_hour == 5'(HOUR_MAX)) ? 5'd0 : o_hour + 5'd1) : o_hour;
   assign w_trig     = i_alarm_en & w_sec_carry &
                       (w_min_nxt == o_alarm_minute) & (w_hour_nxt == o_alarm_hour);

   // previous-cycle samples for edge detection
   always_ff @(posedge clk) begin
      if (reset) begin
         r_set_d <= 1'b0;
         r_inc_d <= 1'b0;
         r_ack_d <= 1'b0;
      end else begin
         r_set_d <= i_set_time;
         r_inc_d <= i_inc;
         r_ack_d <= i_alarm_ack;
      end
   end

   // set-mode FSM steps once per set_time edge
   always_ff @(posedge clk) begin
      if (reset)
         r_mode <= MODE_RUN;
      else if (w_set_ev)
         r_mode <= next_mode(r_mode);
   end

   // prescaler; a seconds inc restarts the second from its beginning
   always_ff @(posedge clk) begin
      if (reset)
         r_presc <= '0;
      else if (w_inc_sec)
         r_presc <= '0;
      else if (w_run)
         r_presc <= (r_presc == P_LAST) ? '0 : r_presc + PW'(1);
   end

   // alarm latch with duration countdown; a fresh trigger outranks any clear
   always_ff @(posedge clk) begin
      if (reset) begin
         r_alarm <= 1'b0;
         r_acnt  <= '0;
      end else if (w_trig) begin
         r_alarm <= 1'b1;
         r_acnt  <= A_LOAD;
      end else if (r_alarm) begin
         if (w_ack_ev || !i_alarm_en) begin
            r_alarm <= 1'b0;
            r_acnt  <= '0;
         end else if (w_tick) begin
            if (r_acnt == AW'(1)) begin
               r_alarm <= 1'b0;
               r_acnt  <= '0;
            end else begin
               r_acnt <= r_acnt - AW'(1);
            end
         end
      end
   end

   rtc_mod_counter #(.MAX(SEC_MAX), .W(6)) u_sec (
      .clk(clk), .reset(reset), .i_en(w_tick), .i_inc(w_inc_sec),
      .o_val(o_second), .o_carry(w_sec_carry));

   rtc_mod_counter #(.MAX(MIN_MAX), .W(6)) u_min (
      .clk(clk), .reset(reset), .i_en(w_sec_carry), .i_inc(w_inc_min),
      .o_val(o_minute), .o_carry(w_min_carry));

   rtc_mod_counter #(.MAX(HOUR_MAX), .W(5)) u_hour (
      .clk(clk), .reset(reset), .i_en(w_min_carry), .i_inc(w_inc_hour),
      .o_val(o_hour), .o_carry(w_unused_hour_carry));

   rtc_mod_counter #(.MAX(MIN_MAX), .W(6)) u_al_min (
      .clk(clk), .reset(reset), .i_en(1'b0), .i_inc(w_inc_almin),
      .o_val(o_alarm_minute), .o_carry(w_unused_almin_carry));

   rtc_mod_counter #(.MAX(HOUR_MAX), .W(5)) u_al_hour (
      .clk(clk), .reset(reset), .i_en(1'b0), .i_inc(w_inc_alhour),
      .o_val(o_alarm_hour), .o_carry(w_unused_alhour_carry));

   assign o_mode     = r_mode;
   assign o_alarm    = r_alarm;
   assign o_sec_tick = w_tick;

endmodule

// File: tb/tb_rtc_alarm_clock.sv
// Bench for rtc_alarm_clock: behavioural model compared every cycle plus literal checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_rtc_alarm_clock;

   localparam int TD = 1;
   localparam int AL = 60;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, set_t, inc, al_en, ack;
   logic [4:0] hour, ahour;
   logic [5:0] minute, second, amin;
   logic       alarm, tick;
   logic [2:0] mode;

   logic rst4, set4, inc4, en4, ack4;
   logic [4:0] h4, ah4;
   logic [5:0] m4, s4, am4;
   logic       al4, t4;
   logic [2:0] mode4;

   rtc_alarm_clock #(.TICK_DIV(TD), .ALARM_LEN(AL)) u_dut (
      .clk(clk), .reset(rst), .i_set_time(set_t), .i_inc(inc),
      .i_alarm_en(al_en), .i_alarm_ack(ack),
      .o_hour(hour), .o_minute(minute), .o_second(second),
      .o_alarm_hour(ahour), .o_alarm_minute(amin), .o_alarm(alarm),
      .o_mode(mode), .o_sec_tick(tick));

   rtc_alarm_clock #(.TICK_DIV(4), .ALARM_LEN(AL)) u_dut4 (
      .clk(clk), .reset(rst4), .i_set_time(set4), .i_inc(inc4),
      .i_alarm_en(en4), .i_alarm_ack(ack4),
      .o_hour(h4), .o_minute(m4), .o_second(s4),
      .o_alarm_hour(ah4), .o_alarm_minute(am4), .o_alarm(al4),
      .o_mode(mode4), .o_sec_tick(t4));

   int checks = 0;
   int passed = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // ---------------- behavioural model (main DUT) ----------------
   int m_h, m_m, m_s, m_ah, m_am, m_mode, m_left, m_presc;
   bit m_alarm, p_set, p_inc, p_ack, m_on;

   initial begin
      m_h = 0; m_m = 0; m_s = 0; m_ah = 0; m_am = 0; m_mode = 0;
      m_left = 0; m_presc = 0; m_alarm = 0; p_set = 0; p_inc = 0; p_ack = 0; m_on = 0;
   end

   always @(posedge clk) begin : model
      bit se, ie, ae, runs, sec_t, wrapped, trig;
      if (rst) begin
         m_h = 0; m_m = 0; m_s = 0; m_ah = 0; m_am = 0; m_mode = 0;
         m_left = 0; m_presc = 0; m_alarm = 0;
         p_set = 0; p_inc = 0; p_ack = 0; m_on = 1;
      end else begin
         se = set_t && !p_set;
         ie = inc && !p_inc;
         ae = ack && !p_ack;
         runs = (m_mode == 0) || (m_mode >= 4);
         sec_t = runs && (m_presc == TD - 1);
         wrapped = 0;
         if (runs) m_presc = sec_t ? 0 : m_presc + 1;
         if (sec_t) begin
            m_s++;
            if (m_s == 60) begin
               m_s = 0; wrapped = 1; m_m++;
               if (m_m == 60) begin m_m = 0; m_h = (m_h + 1) % 24; end
            end
         end
         trig = al_en && wrapped && (m_h == m_ah) && (m_m == m_am);
         if (trig) begin
            m_alarm = 1; m_left = AL;
         end else if (m_alarm) begin
            if (ae || !al_en) m_alarm = 0;
            else if (sec_t) begin
               m_left--;
               if (m_left == 0) m_alarm = 0;
            end
         end
         if (ie) begin
            case (m_mode)
               1: begin m_s = (m_s + 1) % 60; m_presc = 0; end
               2: m_m = (m_m + 1) % 60;
               3: m_h = (m_h + 1) % 24;
               4: m_am = (m_am + 1) % 60;
               5: m_ah = (m_ah + 1) % 24;
               default: ;
            endcase
         end
         if (se) m_mode = (m_mode + 1) % 6;
         p_set = set_t; p_inc = inc; p_ack = ack;
      end
   end

   always @(negedge clk) begin : compare
      bit exp_tick;
      if (m_on) begin
         exp_tick = !rst && ((m_mode == 0) || (m_mode >= 4)) && (m_presc == TD - 1);
         checks++;
         if (hour == m_h && minute == m_m && second == m_s && ahour == m_ah &&
             amin == m_am && alarm == m_alarm && mode == m_mode && tick == exp_tick)
            passed++;
         else
            $display("FAIL model_cycle t=%0t: got %0d:%0d:%0d al=%0d:%0d alarm=%0d mode=%0d tick=%0d, expected %0d:%0d:%0d al=%0d:%0d alarm=%0d mode=%0d tick=%0d",
                     $time, hour, minute, second, ahour, amin, alarm, mode, tick,
                     m_h, m_m, m_s, m_ah, m_am, m_alarm, m_mode, exp_tick);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   task automatic pulse_set();
      set_t = 1; step(2); set_t = 0; step(2);
   endtask

   task automatic pulse_inc();
      inc = 1; step(2); inc = 0; step(2);
   endtask

   task automatic do_reset();
      rst = 1; step(2); rst = 0;
   endtask

   task automatic program_alarm(input int am);
      repeat (4) pulse_set();
      repeat (am) pulse_inc();
      repeat (2) pulse_set();
   endtask

   task automatic wait_hms(input int h, input int m, input int s, input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget && !ok; i++) begin
         if (hour == h && minute == m && second == s) ok = 1;
         else step(1);
      end
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit ok;
      int n;
      rst = 1; rst4 = 1; set_t = 0; inc = 0; al_en = 1; ack = 0;
      set4 = 0; inc4 = 0; en4 = 0; ack4 = 0;
      step(3);
      check("rst_hour", hour, 0);
      check("rst_mode", mode, 0);
      check("rst_alarm", alarm, 0);
      check("rst_tick_td1", tick, 0);
      check("rst_tick_td4", t4, 0);

      // divide-by-4 instance: tick every 4th cycle, two seconds after ten edges
      rst4 = 0;
      for (int k = 0; k < 10; k++) begin
         check($sformatf("div4_tick%0d", k), t4, (k % 4 == 3) ? 1 : 0);
         step(1);
      end
      check("div4_second", s4, 2);
      check("div4_minute", m4, 0);

      // 3661 free-running seconds -> 01:01:01, alarm 00:00 never fires
      rst = 0;
      step(3661);
      check("run_hour", hour, 1);
      check("run_minute", minute, 1);
      check("run_second", second, 1);
      check("run_no_alarm", alarm, 0);

      // set seconds: the release edge still ticks once, then time freezes at 1
      do_reset();
      pulse_set();
      check("set_mode1", mode, 1);
      repeat (8) pulse_inc();
      check("set_sec9", second, 9);
      check("set_min_unchanged", minute, 0);
      step(5);
      check("frozen_sec", second, 9);
      check("frozen_tick", tick, 0);
      repeat (50) pulse_inc();
      check("set_sec59", second, 59);
      pulse_inc();
      check("set_sec_wrap", second, 0);
      check("set_sec_wrap_nocarry", minute, 0);

      pulse_set();
      check("set_mode2", mode, 2);
      inc = 1; step(10); inc = 0; step(2);
      check("held_inc_once", minute, 1);
      pulse_set();
      repeat (24) pulse_inc();
      check("hour_wrap", hour, 0);
      pulse_inc();
      check("hour_inc", hour, 1);
      check("hour_inc_min", minute, 1);
      repeat (3) pulse_set();
      check("back_to_run", mode, 0);
      pulse_inc();

      // alarm 00:02, no ack: rises at 00:02:00 and lasts 60 ticks
      do_reset();
      program_alarm(2);
      wait_hms(0, 1, 59, 400, ok);
      check("wait_a", ok, 1);
      step(1);
      check("trig_alarm", alarm, 1);
      check("trig_min", minute, 2);
      check("trig_sec", second, 0);
      n = 0;
      while (alarm && n < 100) begin step(1); n++; end
      check("alarm_duration", n, 60);

      // ack five cycles after trigger clears on the next edge
      do_reset();
      program_alarm(2);
      wait_hms(0, 1, 59, 400, ok);
      check("wait_b", ok, 1);
      step(1);
      check("trig_b", alarm, 1);
      step(4);
      ack = 1; step(1);
      check("ack_clear", alarm, 0);
      ack = 0; step(2);

      // ack coinciding with trigger loses; alarm_en low clears
      do_reset();
      program_alarm(2);
      wait_hms(0, 1, 59, 400, ok);
      check("wait_c", ok, 1);
      ack = 1; step(1);
      check("trig_beats_ack", alarm, 1);
      ack = 0; step(3);
      al_en = 0; step(1);
      check("en_clear", alarm, 0);
      al_en = 1; step(2);

      // reprogram during alarm, then reset from SET_HOUR with alarm active
      do_reset();
      program_alarm(2);
      wait_hms(0, 1, 59, 400, ok);
      check("wait_d", ok, 1);
      step(1);
      repeat (4) pulse_set();
      pulse_inc();
      check("reprog_almin", amin, 3);
      check("reprog_keeps_alarm", alarm, 1);
      repeat (5) pulse_set();
      check("pre_rst_mode", mode, 3);
      check("pre_rst_alarm", alarm, 1);
      rst = 1; step(1);
      check("rst2_hour", hour, 0);
      check("rst2_min", minute, 0);
      check("rst2_sec", second, 0);
      check("rst2_almin", amin, 0);
      check("rst2_mode", mode, 0);
      check("rst2_alarm", alarm, 0);
      check("rst2_tick", tick, 0);
      rst = 0; step(1);
      check("post_rst_sec", second, 1);
      check("post_rst_no_trig", alarm, 0);
      step(2);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
